// File: rtl/nes_controller_responder_if.sv
// Three-wire NES pad port plus the button source and frame status seen by the responder.
// The master drives buttons and the host pins; the slave is the responder itself.
interface nes_controller_responder_if;
    logic [7:0] buttons;
    logic       nes_latch;
    logic       nes_clk;
    logic       nes_data;
    logic       frame_done;
    logic       busy;
    logic [7:0] latched_buttons;

    modport master (
        output buttons, nes_latch, nes_clk,
        input  nes_data, frame_done, busy, latched_buttons
    );

    modport slave (
        input  buttons, nes_latch, nes_clk,
        output nes_data, frame_done, busy, latched_buttons
    );
endinterface

// File: rtl/nes_controller_responder.sv
// Controller side of the NES serial pad protocol: conditions the asynchronous host
// latch/clock pins and shifts the active-low button snapshot out on nes_data.
module nes_controller_responder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter bit          FILL_BIT      = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    nes_controller_responder_if.slave  bus
);
    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    // Index 0 conditions nes_latch, index 1 conditions nes_clk.
    logic [1:0]             pin;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [SYNC_STAGES-1:0] sync_d [2];
    logic [CW-1:0]          cnt_q  [2];
    logic [CW-1:0]          cnt_d  [2];
    logic [1:0]             flt_q, flt_d;
    logic [1:0]             rise_q, rise_d;
    logic                   lat_fall_q, lat_fall_d;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       data_q, data_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] latched_q, latched_d;

    assign pin = {bus.nes_clk, bus.nes_latch};

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pin[i]};
            flt_d[i]  = flt_q[i];
            cnt_d[i]  = '0;
            // The filtered level only follows after FILTER_CYCLES disagreeing samples in a row.
            if (sync_q[i][SYNC_STAGES-1] != flt_q[i]) begin
                if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
                    flt_d[i] = sync_q[i][SYNC_STAGES-1];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            rise_d[i] = flt_d[i] & ~flt_q[i];
        end
        lat_fall_d = ~flt_d[0] & flt_q[0];
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        latched_d    = latched_q;

        // A latch rise beats a simultaneous clock rise and aborts any frame in flight.
        if (rise_q[0]) begin
            state_d = LOAD;
            shreg_d = ~bus.buttons;
            data_d  = ~bus.buttons[7];
        end else begin
            unique case (state_q)
                IDLE: data_d = 1'b1;
                LOAD: begin
                    shreg_d = ~bus.buttons;
                    data_d  = ~bus.buttons[7];
                    if (lat_fall_q) begin
                        latched_d = bus.buttons;
                        bitcnt_d  = 3'd0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_q[1]) begin
                        if (bitcnt_q == 3'd7) begin
                            frame_done_d = 1'b1;
                            data_d       = FILL_BIT;
                            state_d      = DONE;
                        end else begin
                            shreg_d  = {shreg_q[6:0], FILL_BIT};
                            bitcnt_d = bitcnt_q + 3'd1;
                            data_d   = shreg_q[6];
                        end
                    end
                end
                DONE:    data_d = FILL_BIT;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '{default: '0};
            cnt_q        <= '{default: '0};
            flt_q        <= '0;
            rise_q       <= '0;
            lat_fall_q   <= 1'b0;
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            data_q       <= 1'b1;
            frame_done_q <= 1'b0;
            latched_q    <= '0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            flt_q        <= flt_d;
            rise_q       <= rise_d;
            lat_fall_q   <= lat_fall_d;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            latched_q    <= latched_d;
        end
    end

    assign bus.nes_data        = data_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.busy            = (state_q == LOAD) || (state_q == SHIFT);
    assign bus.latched_buttons = latched_q;
endmodule

// File: tb/tb_nes_controller_responder.sv
// Bench for nes_controller_responder: two instances (FILL_BIT 1 and 0) share one stimulus;
// table-driven frames, hand-written corner sequences, then random host activity vs a frame model.
module tb_nes_controller_responder;
    logic clk;
    logic reset;

    nes_controller_responder_if bus ();
    nes_controller_responder_if bus0 ();

    assign bus0.buttons   = bus.buttons;
    assign bus0.nes_latch = bus.nes_latch;
    assign bus0.nes_clk   = bus.nes_clk;

    nes_controller_responder #(.FILL_BIT(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    nes_controller_responder #(.FILL_BIT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int fd1_cnt = 0;
    int fd0_cnt = 0;
    logic fd1_prev = 1'b0;
    logic fd0_prev = 1'b0;
    int fd_exp;

    typedef struct {
        bit         is_latch;
        logic [7:0] btn;
        logic       d1;
        logic       d0;
        logic       bsy;
        logic [7:0] lat;
        int         fd;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // frame_done must be a single cycle and coincide with nes_data showing the fill level.
    always @(negedge clk) begin
        if (bus.frame_done) begin
            fd1_cnt++;
            check("fd1_data", bus.nes_data, 1);
            check("fd1_width", fd1_prev, 0);
        end
        if (bus0.frame_done) begin
            fd0_cnt++;
            check("fd0_data", bus0.nes_data, 0);
            check("fd0_width", fd0_prev, 0);
        end
        fd1_prev = bus.frame_done;
        fd0_prev = bus0.frame_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic latch_pulse(input logic [7:0] btn, input int len);
        bus.buttons   = btn;
        bus.nes_latch = 1'b1;
        tick(len / 2);
        @(negedge clk);
        check("busy_load", bus.busy, 1);
        tick(len - len / 2);
        bus.nes_latch = 1'b0;
        tick(12);
    endtask

    task automatic clk_pulse(input int hi, input int lo);
        bus.nes_clk = 1'b1;
        tick(hi);
        bus.nes_clk = 1'b0;
        tick(lo);
    endtask

    task automatic expect_state(input string tag, input logic d1, input logic d0,
                                input logic bsy, input logic [7:0] lat, input int fd);
        @(negedge clk);
        check({tag, ".data1"}, bus.nes_data, d1);
        check({tag, ".data0"}, bus0.nes_data, d0);
        check({tag, ".busy"}, bus.busy, bsy);
        check({tag, ".busy0"}, bus0.busy, bsy);
        check({tag, ".latched"}, bus.latched_buttons, lat);
        check({tag, ".fdlvl"}, bus.frame_done, 0);
        check({tag, ".fd1"}, fd1_cnt, fd);
        check({tag, ".fd0"}, fd0_cnt, fd);
        tick(1);
    endtask

    // Reference model: host-level view of the frame (snapshot + number of clocks consumed).
    bit         m_active;
    int         m_k;
    logic [7:0] m_snap;

    function automatic logic model_data(input logic fill);
        if (!m_active) return 1'b1;
        if (m_k < 8) return ~m_snap[7 - m_k];
        return fill;
    endfunction

    initial begin
        logic [7:0] b;
        logic [7:0] ba;
        int r;

        vecs = '{
            '{1'b1, 8'h94, 1'b0, 1'b0, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h94, 1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h94, 1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h94, 1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h94, 1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h94, 1},
            '{1'b1, 8'h94, 1'b0, 1'b0, 1'b1, 8'h94, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h94, 1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h94, 1},
            '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1}
        };

        reset         = 1'b1;
        bus.buttons   = 8'h00;
        bus.nes_latch = 1'b0;
        bus.nes_clk   = 1'b0;
        tick(3);
        reset = 1'b0;
        expect_state("reset", 1, 1, 0, 8'h00, 0);

        // Short latch pulse in IDLE must be filtered out.
        bus.nes_latch = 1'b1;
        tick(2);
        bus.nes_latch = 1'b0;
        tick(12);
        expect_state("lat_glitch", 1, 1, 0, 8'h00, 0);

        // Basic frame, extra clocks, and abort, at host timing (152 cycles per half period).
        for (int i = 0; i < 25; i++) begin
            if (vecs[i].is_latch) latch_pulse(vecs[i].btn, 152);
            else clk_pulse(152, 152);
            expect_state($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d0, vecs[i].bsy,
                         vecs[i].lat, vecs[i].fd);
        end
        clk_pulse(152, 152);
        expect_state("abort_end", 1, 0, 0, 8'h01, 2);
        fd_exp = 2;

        // Clock glitch in SHIFT: neither data nor bit count may move.
        b = 8'hA5;
        latch_pulse(b, 30);
        clk_pulse(10, 10);
        clk_pulse(10, 10);
        expect_state("cg_pre", ~b[5], ~b[5], 1, b, fd_exp);
        bus.nes_clk = 1'b1;
        tick(3);
        bus.nes_clk = 1'b0;
        tick(12);
        expect_state("cg_post", ~b[5], ~b[5], 1, b, fd_exp);
        clk_pulse(10, 10);
        expect_state("cg_next", ~b[4], ~b[4], 1, b, fd_exp);
        repeat (4) clk_pulse(10, 10);
        expect_state("cg_7th", ~b[0], ~b[0], 1, b, fd_exp);
        clk_pulse(10, 10);
        fd_exp++;
        expect_state("cg_8th", 1, 0, 0, b, fd_exp);

        // Latch and clock rising together in SHIFT: latch wins, no shift.
        latch_pulse(8'h94, 30);
        clk_pulse(10, 10);
        clk_pulse(10, 10);
        b = 8'h40;
        bus.buttons   = b;
        bus.nes_latch = 1'b1;
        bus.nes_clk   = 1'b1;
        tick(20);
        bus.nes_clk = 1'b0;
        tick(20);
        bus.nes_latch = 1'b0;
        tick(12);
        expect_state("coll_load", ~b[7], ~b[7], 1, b, fd_exp);
        clk_pulse(10, 10);
        expect_state("coll_1st", ~b[6], ~b[6], 1, b, fd_exp);
        repeat (7) clk_pulse(10, 10);
        fd_exp++;
        expect_state("coll_end", 1, 0, 0, b, fd_exp);

        // Reset mid-frame, then a clean frame decoded bit by bit.
        latch_pulse(8'h94, 30);
        repeat (4) clk_pulse(10, 10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_state("midrst", 1, 1, 0, 8'h00, fd_exp);
        b = 8'h3C;
        latch_pulse(b, 30);
        expect_state("rf0", ~b[7], ~b[7], 1, b, fd_exp);
        for (int k = 1; k < 8; k++) begin
            clk_pulse(10, 10);
            expect_state($sformatf("rf%0d", k), ~b[7 - k], ~b[7 - k], 1, b, fd_exp);
        end
        clk_pulse(10, 10);
        fd_exp++;
        expect_state("rf8", 1, 0, 0, b, fd_exp);

        // Random host activity against the frame-level model.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        m_active = 1'b0;
        m_k      = 0;
        m_snap   = 8'h00;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                ba = 8'($urandom);
                b  = 8'($urandom);
                bus.buttons   = ba;
                bus.nes_latch = 1'b1;
                tick($urandom_range(3, 10));
                bus.buttons = b;
                tick($urandom_range(10, 20));
                bus.nes_latch = 1'b0;
                tick(12);
                bus.buttons = 8'($urandom);
                m_active = 1'b1;
                m_k      = 0;
                m_snap   = b;
            end else if (r <= 7) begin
                clk_pulse($urandom_range(5, 12), $urandom_range(8, 14));
                if (m_active && m_k < 8) begin
                    m_k++;
                    if (m_k == 8) fd_exp++;
                end
            end else if (r == 8) begin
                bus.nes_clk = 1'b1;
                tick($urandom_range(1, 3));
                bus.nes_clk = 1'b0;
                tick(10);
            end else begin
                bus.nes_latch = 1'b1;
                tick($urandom_range(1, 3));
                bus.nes_latch = 1'b0;
                tick(10);
            end
            expect_state($sformatf("rnd%0d", n), model_data(1'b1), model_data(1'b0),
                         m_active && (m_k < 8), m_snap, fd_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/nes_controller_responder.md
# nes_controller_responder

Emulates the controller side of the NES serial pad protocol: it answers the latch/clock pulses driven by the pong datapath's controller poller with a serial, active-low button stream on the data line. It sits between a button source (on-board switches, a test harness or a replay block) and the same 3-wire port that a physical NES pad would occupy. Host latch and clock inputs are asynchronous to `clk`, so they are synchronized and glitch-filtered before edge detection.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each input synchronizer; legal values are 2 or more.
- `FILTER_CYCLES`, default 4: consecutive `clk` samples an input must hold before its filtered value changes; legal values are 1 or more.
- `FILL_BIT`, default 1: level driven on `nes_data` after the 8 button bits have been shifted out.
- `clk` input 1: system clock, 25.175 MHz nominal.
- `reset` input 1: synchronous, active-high reset.
- `buttons` input 8: pressed = 1. Bit order is [7] A, [6] B, [5] Select, [4] Start, [3] Up, [2] Down, [1] Left, [0] Right.
- `nes_latch` input 1: host latch, asynchronous, active-high.
- `nes_clk` input 1: host shift clock, asynchronous; the rising edge advances the shift.
- `nes_data` output 1: serial data to the host, active-low (0 = pressed).
- `frame_done` output 1: one-`clk` pulse when the 8th bit has been consumed.
- `busy` output 1: high from latch until `frame_done` or abort.
- `latched_buttons` output 8: snapshot of `buttons` taken at the latch falling edge.

## Operation
- Input conditioning is applied separately to `nes_latch` and `nes_clk`:
  - Synchronizer of `SYNC_STAGES` flops.
  - Stability filter with a counter of width clog2(`FILTER_CYCLES`+1). The filtered value changes only after `FILTER_CYCLES` identical consecutive samples.
  - Edge detection on the filtered value, giving `lat_rise`, `lat_fall` and `clk_rise`.
- The state machine has four states: IDLE, LOAD, SHIFT and DONE.
  - IDLE: `nes_data` = 1, `busy` = 0. `lat_rise` moves to LOAD.
  - LOAD (filtered latch high): every cycle, shreg <= ~`buttons` and `nes_data` <= ~`buttons`[7]. `clk_rise` is ignored while in LOAD. `lat_fall` captures `latched_buttons` <= `buttons`, sets bitcnt = 0 and moves to SHIFT.
  - SHIFT: `nes_data` = shreg[7]. On `clk_rise`, shreg <= {shreg[6:0], `FILL_BIT`} and bitcnt increments.
    - When bitcnt reaches 7 (8th bit already presented) and `clk_rise` occurs, pulse `frame_done`, set `nes_data` <= `FILL_BIT` and move to DONE.
  - DONE: `nes_data` = `FILL_BIT`. Further `clk_rise` events keep `FILL_BIT` and do not pulse `frame_done` again. `lat_rise` moves to LOAD.
- Latch re-asserted in SHIFT (abort): go to LOAD and reload; `frame_done` is not pulsed. `busy` stays high.
- A `clk_rise` and a `lat_rise` in the same cycle: the latch wins, the state goes to LOAD and no shift occurs.
- `busy` is 1 in LOAD and SHIFT and 0 in IDLE and DONE.
- `bitcnt` is 3 bits and is saturated by the state change to DONE; it never wraps.

## Timing
- Reset values: `nes_data` = 1, `frame_done` = 0, `busy` = 0, `latched_buttons` = 8'h00, state = IDLE. All synchronizers and filters are preloaded to 0.
  - Reset mid-frame takes effect on the next `clk` edge regardless of state.
- Input-to-edge latency is `SYNC_STAGES` + `FILTER_CYCLES` cycles from the pin change to the registered edge strobe. With defaults this is 6 cycles, about 238 ns.
- `nes_data` is registered and updates 1 cycle after the edge strobe. Total pin-to-data latency with defaults is 7 cycles, about 278 ns.
  - This must be well under the host's 6 µs latch width and 6 µs clock half-period (152-count delay at 25.175 MHz).
- `nes_data` shows A (~`buttons`[7]) no later than 7 cycles after the latch rises. The host samples A before the first clock pulse.
- `frame_done` is high for exactly 1 cycle, the same cycle that `nes_data` changes to `FILL_BIT`.
- Pulses shorter than `FILTER_CYCLES` cycles on either input are ignored and produce no state change.

## Test plan
- Basic frame: `buttons` = 8'b1001_0100 (A, Start, Down). Drive latch high for 6 µs, then 8 clock pulses at 12 µs period.
  - `nes_data` sampled after latch and after each of the first 7 rising edges reads 0,1,1,0,1,0,1,1.
  - `frame_done` pulses on the 8th rising edge, `latched_buttons` = 8'h94, and `nes_data` = 1 afterwards.
- Extra clocks: after a frame, 4 more clock pulses give `nes_data` = `FILL_BIT` (1) with no further `frame_done`. Rerun with `FILL_BIT` = 0 and expect `nes_data` = 0.
- Abort: latch re-asserted after 3 clocks with `buttons` changed to 8'h01.
  - No `frame_done`; `busy` stays 1.
  - The new frame reads 1,1,1,1,1,1,1,0.
- Glitch rejection: a 3-cycle high pulse on `nes_clk` in SHIFT leaves `nes_data` and the bit count unchanged. A 2-cycle `nes_latch` pulse in IDLE leaves the state at IDLE.
- Latch/clock collision: raise `nes_clk` while latch is high.
  - No shift occurs; `nes_data` = ~`buttons`[7] after the latch falls.
- Reset mid-frame: assert `reset` for 1 cycle after 4 clocks.
  - Next cycle: `nes_data` = 1, `busy` = 0, `frame_done` = 0, `latched_buttons` = 8'h00.
  - A subsequent full frame decodes correctly.
